mdu_scheduler: RTL
==================

# mdu_scheduler

Multiply/divide unit scheduler for the five-stage MIPS pipeline. It accepts HI/LO-class instructions from the E stage, sequences multi-cycle multiply and divide operations with a busy counter, commits results into the architectural HI/LO registers, and drives the D-stage stall for HI/LO-class instructions while the unit is occupied. It sits beside the E-stage ALU and feeds the MFHI/MFLO read path into the E-stage result mux.

## Interface
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (and MADD-class when enabled); must be ≥1
- DIV_CYCLES, 10, busy cycles for DIV/DIVU; must be ≥1
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-low (0 = reset at the rising edge of clk)
- req_valid  in  1  E-stage instruction is HI/LO-class
- req_kill  in  1  E-stage instruction is being cancelled by an exception or interrupt this cycle
- op_E  in  4  encoded operation (mdu_pkg)
- rs_data  in  32  forwarded rs operand
- rt_data  in  32  forwarded rt operand
- md_use_D  in  1  D-stage instruction is HI/LO-class, including MFHI/MFLO
- busy  out  1  multi-cycle operation in flight
- stall_md  out  1  stall request to the hazard unit
- hi  out  32  architectural HI
- lo  out  32  architectural LO
- mf_data  out  32  HI for MFHI, LO for MFLO, else 0

## Operation
- Op encoding: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO, 9 MADD, 10 MADDU, 11 MSUB, 12 MSUBU; unlisted codes behave as NONE.
- accept = reset & req_valid & ~req_kill & ~busy.
- FSM states:
  - IDLE → BUSY on accepted MULT/MULTU/DIV/DIVU/MADD-class. The counter loads MULT_CYCLES or DIV_CYCLES, and the result is computed and latched into pend_hi/pend_lo.
  - In BUSY, the counter decrements each cycle. When the counter reaches 1, the next edge copies pend into HI/LO and returns to IDLE.
- MTHI/MTLO write rs_data into HI/LO at the accept edge. No busy.
- MFHI/MFLO only select mf_data and have no state effect.
- MULT gives signed 64-bit {HI,LO}. MULTU gives unsigned.
- DIV is signed: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend. 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0.
- DIVU is unsigned.
- Divide by zero: HI/LO keep their old values, and the unit still occupies DIV_CYCLES.
- An in-flight operation is never cancelled by req_kill. Only a request in its accept cycle is suppressed.
- A request while busy is ignored. The pipeline stall guarantees this never happens legally.
- stall_md = md_use_D & (busy | (accept & op is multi-cycle)).

## Timing
- Reset values: hi = 0, lo = 0, busy = 0, counter = 0, pend = 0, FSM = IDLE. stall_md = 0 while reset is low.
- Reset mid-operation aborts the operation. Nothing is committed.
- For a multi-cycle op accepted in cycle k with N cycles:
  - busy is high in cycles k+1 through k+N.
  - New HI/LO are visible from cycle k+N+1, when busy is already low.
  - The next request can be accepted in cycle k+N+1.
- stall_md can be high in cycles k through k+N.
- MTHI/MTLO accepted in cycle k are visible in cycle k+1.
- mf_data is combinational from op_E, hi and lo.

## Configuration
- MDU_MADD_EN defined:
  - MADD/MADDU: {HI,LO} += signed/unsigned product.
  - MSUB/MSUBU: {HI,LO} −= signed/unsigned product.
  - Each takes MULT_CYCLES, using the HI/LO value at accept time.
- MDU_MADD_EN undefined: codes 9–12 decode as NONE, with no busy and no state change.

## Structure
- mdu_pkg holds:
  - the op encoding constants;
  - the FSM state typedef (IDLE, BUSY);
  - the default MULT_CYCLES/DIV_CYCLES constants.
- Sub-module mdu_calc is purely combinational. It takes op, rs, rt, hi and lo, and produces the 64-bit result plus a div_by_zero flag.
- The scheduler owns the FSM, counter, pend registers, HI/LO and the stall logic.

## Test plan
- MULT rs = 0xFFFFFFFE, rt = 3 at cycle 0:
  - busy high in cycles 1–5;
  - HI = 0xFFFFFFFF and LO = 0xFFFFFFFA visible in cycle 6.
- DIV rs = 0xFFFFFFF9 (−7), rt = 2: LO = 0xFFFFFFFD, HI = 0xFFFFFFFF after 10 busy cycles.
- DIVU by 0 after MTHI 0x1234 and MTLO 0x5678: HI/LO unchanged, busy still 10 cycles.
- md_use_D held high across a MULT: stall_md high in cycles 0–5 and low in cycle 6.
- req_kill asserted with MULT: busy stays 0 and HI/LO are unchanged.
- Reset low at cycle 3 of a DIV: next cycle busy = 0 and HI = LO = 0.
- With MDU_MADD_EN, MADDU 2×3 on HI/LO = 0/0xFFFFFFFF: HI = 1, LO = 5.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: op encoding, FSM state type and default latencies for the
// multiply/divide unit scheduler. Optional feature macro: MDU_MADD_EN
// (enables the MADD/MADDU/MSUB/MSUBU accumulate ops).
package mdu_pkg;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MFHI  = 4'd7,
        OP_MFLO  = 4'd8,
        OP_MADD  = 4'd9,
        OP_MADDU = 4'd10,
        OP_MSUB  = 4'd11,
        OP_MSUBU = 4'd12
    } mdu_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mdu_state_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // True for ops that occupy the unit for several cycles.
    function automatic logic is_multi_op(input logic [3:0] op);
        logic m;
        m = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
`ifdef MDU_MADD_EN
        m = m || (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
`endif
        return m;
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// mdu_calc: purely combinational multiply/divide datapath. Produces the
// 64-bit {HI,LO} result for the given op; unknown ops return {hi,lo}.
// Accumulate ops only exist when MDU_MADD_EN is defined.
module mdu_calc
    import mdu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [63:0] result,
    output logic        div_by_zero
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] rs_mag;
    logic [31:0] rt_mag;
    logic [31:0] rt_safe;
    logic [31:0] rt_mag_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] q_s;
    logic [31:0] r_s;
    logic [31:0] q_u;
    logic [31:0] r_u;
    logic        rt_zero;

    // Low 64 bits of the product of sign-extended operands equal the signed product.
    assign prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
    assign prod_u = {32'd0, rs} * {32'd0, rt};

    // Signed divide via magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
    assign rt_zero     = (rt == 32'd0);
    assign rs_mag      = rs[31] ? (~rs + 32'd1) : rs;
    assign rt_mag      = rt[31] ? (~rt + 32'd1) : rt;
    assign rt_safe     = rt_zero ? 32'd1 : rt;
    assign rt_mag_safe = rt_zero ? 32'd1 : rt_mag;
    assign q_mag       = rs_mag / rt_mag_safe;
    assign r_mag       = rs_mag % rt_mag_safe;
    assign q_s         = (rs[31] ^ rt[31]) ? (~q_mag + 32'd1) : q_mag;
    assign r_s         = rs[31] ? (~r_mag + 32'd1) : r_mag;
    assign q_u         = rs / rt_safe;
    assign r_u         = rs % rt_safe;

    // Select the result for the requested op.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        result      = {hi, lo};
        div_by_zero = 1'b0;
        case (op)
            OP_MULT:  result = prod_s;
            OP_MULTU: result = prod_u;
            OP_DIV: begin
                div_by_zero = rt_zero;
                if (!rt_zero) result = {r_s, q_s};
            end
            OP_DIVU: begin
                div_by_zero = rt_zero;
                if (!rt_zero) result = {r_u, q_u};
            end
`ifdef MDU_MADD_EN
            OP_MADD:  result = {hi, lo} + prod_s;
            OP_MADDU: result = {hi, lo} + prod_u;
            OP_MSUB:  result = {hi, lo} - prod_s;
            OP_MSUBU: result = {hi, lo} - prod_u;
`endif
            default:  result = {hi, lo};
        endcase
    end

endmodule

// File: rtl/mdu_scheduler.sv
// mdu_scheduler: sequences multi-cycle MULT/DIV ops with a busy counter,
// owns architectural HI/LO, and raises the D-stage stall for HI/LO-class
// instructions while the unit is occupied. Optional macro: MDU_MADD_EN.
module mdu_scheduler
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_kill,
    input  logic [3:0]  op_E,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        md_use_D,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mf_data
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    mdu_state_e       state_q;
    mdu_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [63:0]      pend_q;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic [63:0]      calc_result;
    logic             div_by_zero;
    logic             accept;
    logic             start;
    logic             last;

    mdu_calc u_calc (
        .op          (op_E),
        .rs          (rs_data),
        .rt          (rt_data),
        .hi          (hi_q),
        .lo          (lo_q),
        .result      (calc_result),
        .div_by_zero (div_by_zero)
    );

    assign busy   = (state_q == BUSY);
    assign accept = reset & req_valid & ~req_kill & ~busy;
    assign start  = accept & is_multi_op(op_E);
    assign last   = (cnt_q == CNT_W'(1));

    // Next-state logic: start a multi-cycle op, return to IDLE on the final count.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = BUSY;
            BUSY:    if (last)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Counter, pending result and architectural HI/LO.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q  <= '0;
            pend_q <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            if (start) begin
                cnt_q  <= is_div_op(op_E) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                // A divide by zero commits the old HI/LO, so the unit stays busy but changes nothing.
                pend_q <= div_by_zero ? {hi_q, lo_q} : calc_result;
            end else if (busy) begin
                cnt_q <= cnt_q - CNT_W'(1);
                if (last) {hi_q, lo_q} <= pend_q;
            end
            if (accept && op_E == OP_MTHI) hi_q <= rs_data;
            if (accept && op_E == OP_MTLO) lo_q <= rs_data;
        end
    end

    assign stall_md = reset & md_use_D & (busy | start);
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign mf_data  = (op_E == OP_MFHI) ? hi_q :
                      (op_E == OP_MFLO) ? lo_q : 32'd0;

endmodule
